// File: rtl/amm_csr_bank.sv
// Avalon-MM control/status register bank with per-bit RW, read-only (hardware-driven)
// and sticky write-1-to-clear bits, a fixed-latency read pipeline and an error counter.
module amm_csr_bank #(
  parameter int REG_CNT  = 32,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1,
  parameter logic [REG_CNT*DATA_W-1:0] RO_MASK = (REG_CNT*DATA_W)'({((REG_CNT+3)/4){
      {DATA_W{1'b1}},
      {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}},
      {{(DATA_W/2){1'b0}}, {(DATA_W/2){1'b1}}},
      {DATA_W{1'b0}}}}),
  parameter logic [REG_CNT*DATA_W-1:0] W1C_MASK = '0,
  parameter logic [REG_CNT*DATA_W-1:0] INIT     = {REG_CNT{DATA_W'(16'hABCD)}},
  localparam int ADDR_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [ADDR_W-1:0]         amm_address_i,
  input  logic                      amm_write_i,
  input  logic [DATA_W-1:0]         amm_writedata_i,
  input  logic [BE_W-1:0]           amm_byteenable_i,
  input  logic                      amm_read_i,
  output logic [DATA_W-1:0]         amm_readdata_o,
  output logic                      amm_readdatavalid_o,
  output logic                      amm_waitrequest_o,
  input  logic [REG_CNT*DATA_W-1:0] hw_ro_i,
  input  logic [REG_CNT*DATA_W-1:0] hw_set_i,
  output logic [REG_CNT*DATA_W-1:0] regs_o,
  output logic                      irq_o,
  output logic [7:0]                err_cnt_o
);

  localparam int TOT_W = REG_CNT * DATA_W;
  // RO wins over W1C where both are set; everything else is plain RW.
  localparam logic [TOT_W-1:0] RO_EFF  = RO_MASK;
  localparam logic [TOT_W-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;
  localparam logic [TOT_W-1:0] RW_EFF  = ~(RO_MASK | W1C_EFF);

  logic [TOT_W-1:0]  reg_q, reg_d;
  logic [TOT_W-1:0]  regs_view;
  logic [TOT_W-1:0]  wr_mask;
  logic [TOT_W-1:0]  wdata_rep;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] rd_sample;
  logic              addr_ok;
  logic [READ_LAT-1:0] pv_q;
  logic [DATA_W-1:0] pd_q [READ_LAT];
  logic [7:0]        err_q;
  logic              irq_q;

  assign addr_ok   = int'(amm_address_i) < REG_CNT;
  assign regs_view = (reg_q & ~RO_EFF) | (hw_ro_i & RO_EFF);
  assign wdata_rep = {REG_CNT{amm_writedata_i}};

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      be_mask[b*8 +: 8] = {8{amm_byteenable_i[b]}};
    end
  end

  always_comb begin
    wr_mask = '0;
    for (int r = 0; r < REG_CNT; r++) begin
      if (amm_write_i && addr_ok && (amm_address_i == ADDR_W'(r))) begin
        wr_mask[r*DATA_W +: DATA_W] = be_mask;
      end
    end
  end

  // A hardware set pulse overrides a host clear issued in the same cycle.
  always_comb begin
    reg_d = (RW_EFF & ((wr_mask & wdata_rep) | (~wr_mask & reg_q)))
          | (W1C_EFF & ((reg_q & ~(wr_mask & wdata_rep)) | hw_set_i));
  end

  always_comb begin
    rd_sample = '0;
    if (addr_ok) begin
      rd_sample = regs_view[int'(amm_address_i)*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      reg_q <= INIT & ~RO_EFF;
      irq_q <= 1'b0;
      err_q <= 8'd0;
    end else begin
      reg_q <= reg_d;
      irq_q <= |(reg_q & W1C_EFF);
      if ((amm_read_i || amm_write_i) && !addr_ok && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  // Each data stage loads only alongside a valid, so the last stage holds between responses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pv_q <= '0;
      for (int i = 0; i < READ_LAT; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= amm_read_i;
      if (amm_read_i) pd_q[0] <= rd_sample;
      for (int i = 1; i < READ_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign amm_readdata_o      = pd_q[READ_LAT-1];
  assign amm_readdatavalid_o = pv_q[READ_LAT-1];
  assign amm_waitrequest_o   = 1'b0;
  assign regs_o              = regs_view;
  assign irq_o               = irq_q;
  assign err_cnt_o           = err_q;

endmodule

// File: tb/tb_amm_csr_bank.sv
// Directed bench for amm_csr_bank: three instances cover the default map (latency 1),
// a W1C register at latency 2, and a 24-register bank at latency 3.
module tb_amm_csr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: all defaults
  logic         a_rst_n, a_write, a_read, a_valid, a_wait, a_irq;
  logic [4:0]   a_addr;
  logic [15:0]  a_wdata, a_rdata;
  logic [1:0]   a_be;
  logic [511:0] a_hw_ro, a_hw_set, a_regs;
  logic [7:0]   a_err;

  // Instance B: reg0 bits 3:0 W1C, reg0 resets to 0, latency 2
  logic         b_rst_n, b_write, b_read, b_valid, b_wait, b_irq;
  logic [4:0]   b_addr;
  logic [15:0]  b_wdata, b_rdata;
  logic [1:0]   b_be;
  logic [511:0] b_hw_ro, b_hw_set, b_regs;
  logic [7:0]   b_err;

  // Instance C: 24 registers, latency 3
  logic         c_rst_n, c_write, c_read, c_valid, c_wait, c_irq;
  logic [4:0]   c_addr;
  logic [15:0]  c_wdata, c_rdata;
  logic [1:0]   c_be;
  logic [383:0] c_hw_ro, c_hw_set, c_regs;
  logic [7:0]   c_err;

  amm_csr_bank dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n), .amm_address_i(a_addr), .amm_write_i(a_write),
    .amm_writedata_i(a_wdata), .amm_byteenable_i(a_be), .amm_read_i(a_read),
    .amm_readdata_o(a_rdata), .amm_readdatavalid_o(a_valid), .amm_waitrequest_o(a_wait),
    .hw_ro_i(a_hw_ro), .hw_set_i(a_hw_set), .regs_o(a_regs), .irq_o(a_irq), .err_cnt_o(a_err)
  );

  amm_csr_bank #(
    .REG_CNT(32), .DATA_W(16), .READ_LAT(2),
    .W1C_MASK(512'h000F), .INIT({{31{16'hABCD}}, 16'h0000})
  ) dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n), .amm_address_i(b_addr), .amm_write_i(b_write),
    .amm_writedata_i(b_wdata), .amm_byteenable_i(b_be), .amm_read_i(b_read),
    .amm_readdata_o(b_rdata), .amm_readdatavalid_o(b_valid), .amm_waitrequest_o(b_wait),
    .hw_ro_i(b_hw_ro), .hw_set_i(b_hw_set), .regs_o(b_regs), .irq_o(b_irq), .err_cnt_o(b_err)
  );

  amm_csr_bank #(.REG_CNT(24), .DATA_W(16), .READ_LAT(3)) dut_c (
    .clk_i(clk), .rst_n_i(c_rst_n), .amm_address_i(c_addr), .amm_write_i(c_write),
    .amm_writedata_i(c_wdata), .amm_byteenable_i(c_be), .amm_read_i(c_read),
    .amm_readdata_o(c_rdata), .amm_readdatavalid_o(c_valid), .amm_waitrequest_o(c_wait),
    .hw_ro_i(c_hw_ro), .hw_set_i(c_hw_set), .regs_o(c_regs), .irq_o(c_irq), .err_cnt_o(c_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ro_word(int r);
    case (r % 4)
      0:       return 16'h0000;
      1:       return 16'h00FF;
      2:       return 16'hFF00;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic test_reset();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", a_valid); end
    checks++; if (a_rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata got=%h exp=0000", a_rdata); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL rst_err got=%0d exp=0", a_err); end
    checks++; if (a_irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%0h exp=0", a_irq); end
    checks++; if (a_wait !== 1'b0) begin failures++; $display("FAIL waitrequest got=%0h exp=0", a_wait); end
    checks++; if (a_regs[0 +: 16] !== 16'hABCD) begin failures++; $display("FAIL rst_reg0 got=%h exp=ABCD", a_regs[0 +: 16]); end
    checks++; if (a_regs[32 +: 16] !== 16'h77CD) begin failures++; $display("FAIL rst_reg2 got=%h exp=77CD", a_regs[32 +: 16]); end
    checks++; if (b_regs[0 +: 16] !== 16'h0000) begin failures++; $display("FAIL rst_b_reg0 got=%h exp=0000", b_regs[0 +: 16]); end
  endtask

  task automatic test_read_ro();
    // Reset released and the read driven together: the first rising edge must accept it.
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    a_read = 1'b1; a_addr = 5'd1;
    tick();
    a_read = 1'b0;
    checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL rd1_valid got=%0h exp=1", a_valid); end
    checks++; if (a_rdata !== 16'hAB34) begin failures++; $display("FAIL rd1_data got=%h exp=AB34", a_rdata); end
    tick();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL rd1_pulse got=%0h exp=0", a_valid); end
    checks++; if (a_rdata !== 16'hAB34) begin failures++; $display("FAIL rd1_hold got=%h exp=AB34", a_rdata); end
    a_hw_ro[16 +: 16] = 16'h1299;
    #1;
    checks++; if (a_regs[16 +: 16] !== 16'hAB99) begin failures++; $display("FAIL ro_live got=%h exp=AB99", a_regs[16 +: 16]); end
  endtask

  task automatic test_write();
    a_write = 1'b1; a_addr = 5'd0; a_wdata = 16'h5A5A; a_be = 2'b01;
    tick();
    checks++; if (a_regs[0 +: 16] !== 16'hAB5A) begin failures++; $display("FAIL wr_be01 got=%h exp=AB5A", a_regs[0 +: 16]); end
    a_addr = 5'd3; a_wdata = 16'hFFFF; a_be = 2'b11;
    tick();
    checks++; if (a_regs[48 +: 16] !== 16'hC3C3) begin failures++; $display("FAIL wr_ro got=%h exp=C3C3", a_regs[48 +: 16]); end
    a_addr = 5'd2; a_wdata = 16'h1111;
    tick();
    a_write = 1'b0;
    checks++; if (a_regs[32 +: 16] !== 16'h7711) begin failures++; $display("FAIL wr_mixed got=%h exp=7711", a_regs[32 +: 16]); end
  endtask

  task automatic test_back_to_back();
    a_write = 1'b1; a_read = 1'b1; a_addr = 5'd0; a_wdata = 16'hFFFF; a_be = 2'b11;
    tick();
    a_write = 1'b0; a_addr = 5'd1;
    checks++; if (a_rdata !== 16'hAB5A || a_valid !== 1'b1) begin failures++; $display("FAIL rdw_pre got=%h/%0h exp=AB5A/1", a_rdata, a_valid); end
    checks++; if (a_regs[0 +: 16] !== 16'hFFFF) begin failures++; $display("FAIL rdw_new got=%h exp=FFFF", a_regs[0 +: 16]); end
    tick();
    a_addr = 5'd2;
    checks++; if (a_rdata !== 16'hAB99 || a_valid !== 1'b1) begin failures++; $display("FAIL b2b_1 got=%h/%0h exp=AB99/1", a_rdata, a_valid); end
    tick();
    a_read = 1'b0;
    checks++; if (a_rdata !== 16'h7711 || a_valid !== 1'b1) begin failures++; $display("FAIL b2b_2 got=%h/%0h exp=7711/1", a_rdata, a_valid); end
    tick();
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0h exp=0", a_valid); end
    checks++; if (a_err !== 8'd0) begin failures++; $display("FAIL a_err got=%0d exp=0", a_err); end
  endtask

  task automatic test_w1c();
    b_hw_set = 512'h4;
    tick();
    b_hw_set = '0;
    checks++; if (b_regs[0 +: 16] !== 16'h0004) begin failures++; $display("FAIL w1c_set got=%h exp=0004", b_regs[0 +: 16]); end
    tick();
    checks++; if (b_irq !== 1'b1) begin failures++; $display("FAIL w1c_irq1 got=%0h exp=1", b_irq); end
    b_write = 1'b1; b_addr = 5'd0; b_wdata = 16'h0004; b_be = 2'b11; b_hw_set = 512'h4;
    tick();
    b_hw_set = '0;
    checks++; if (b_regs[0 +: 16] !== 16'h0004) begin failures++; $display("FAIL w1c_setwins got=%h exp=0004", b_regs[0 +: 16]); end
    tick();
    b_write = 1'b0;
    checks++; if (b_regs[0 +: 16] !== 16'h0000) begin failures++; $display("FAIL w1c_clear got=%h exp=0000", b_regs[0 +: 16]); end
    tick();
    checks++; if (b_irq !== 1'b0) begin failures++; $display("FAIL w1c_irq0 got=%0h exp=0", b_irq); end
    b_hw_set = 512'h5;
    tick();
    b_hw_set = '0; b_write = 1'b1; b_wdata = 16'hA5F1; b_be = 2'b11;
    tick();
    checks++; if (b_regs[0 +: 16] !== 16'hA5F4) begin failures++; $display("FAIL w1c_mix got=%h exp=A5F4", b_regs[0 +: 16]); end
    b_wdata = 16'h12FF; b_be = 2'b10;
    tick();
    b_write = 1'b0;
    checks++; if (b_regs[0 +: 16] !== 16'h12F4) begin failures++; $display("FAIL w1c_lane got=%h exp=12F4", b_regs[0 +: 16]); end
    b_read = 1'b1;
    tick();
    b_read = 1'b0;
    checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL lat2_early got=%0h exp=0", b_valid); end
    tick();
    checks++; if (b_valid !== 1'b1 || b_rdata !== 16'h12F4) begin failures++; $display("FAIL lat2_rsp got=%h/%0h exp=12F4/1", b_rdata, b_valid); end
  endtask

  task automatic test_reset_flush();
    logic [511:0] exp_regs;
    bit seen;
    b_write = 1'b1; b_addr = 5'd5; b_wdata = 16'hFFFF; b_be = 2'b11;
    tick();
    b_write = 1'b0;
    checks++; if (b_regs[80 +: 16] !== 16'hFF00) begin failures++; $display("FAIL b_reg5 got=%h exp=FF00", b_regs[80 +: 16]); end
    b_read = 1'b1;
    tick();
    b_read = 1'b0; b_rst_n = 1'b0;
    #1;
    checks++; if (b_valid !== 1'b0 || b_rdata !== 16'h0000) begin failures++; $display("FAIL flush_now got=%h/%0h exp=0000/0", b_rdata, b_valid); end
    tick();
    b_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (b_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0h exp=0", seen); end
    for (int r = 0; r < 32; r++) begin
      exp_regs[r*16 +: 16] = ((r == 0) ? 16'h0000 : 16'hABCD) & ~ro_word(r);
    end
    checks++; if (b_regs !== exp_regs) begin failures++; $display("FAIL flush_init got=%h exp=%h", b_regs[95:0], exp_regs[95:0]); end
  endtask

  task automatic test_out_of_range();
    c_read = 1'b1; c_addr = 5'd5;
    tick();
    c_addr = 5'd30;
    checks++; if (c_valid !== 1'b0) begin failures++; $display("FAIL lat3_e0 got=%0h exp=0", c_valid); end
    tick();
    c_addr = 5'd6;
    tick();
    c_read = 1'b0;
    checks++; if (c_valid !== 1'b1 || c_rdata !== 16'hAB00) begin failures++; $display("FAIL lat3_r0 got=%h/%0h exp=AB00/1", c_rdata, c_valid); end
    tick();
    checks++; if (c_valid !== 1'b1 || c_rdata !== 16'h0000) begin failures++; $display("FAIL lat3_r1 got=%h/%0h exp=0000/1", c_rdata, c_valid); end
    tick();
    checks++; if (c_valid !== 1'b1 || c_rdata !== 16'h00CD) begin failures++; $display("FAIL lat3_r2 got=%h/%0h exp=00CD/1", c_rdata, c_valid); end
    tick();
    checks++; if (c_valid !== 1'b0 || c_rdata !== 16'h00CD) begin failures++; $display("FAIL lat3_hold got=%h/%0h exp=00CD/0", c_rdata, c_valid); end
    checks++; if (c_err !== 8'd1) begin failures++; $display("FAIL err_one got=%0d exp=1", c_err); end
    c_read = 1'b1; c_write = 1'b1; c_addr = 5'd25; c_wdata = 16'hFFFF; c_be = 2'b11;
    tick();
    c_read = 1'b0;
    checks++; if (c_err !== 8'd2) begin failures++; $display("FAIL err_rw_once got=%0d exp=2", c_err); end
    c_addr = 5'd28;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (c_err !== 8'd12) begin failures++; $display("FAIL err_twelve got=%0d exp=12", c_err); end
    for (int i = 0; i < 290; i++) tick();
    c_write = 1'b0;
    checks++; if (c_err !== 8'd255) begin failures++; $display("FAIL err_sat got=%0d exp=255", c_err); end
    checks++; if (c_regs[64 +: 16] !== 16'hABCD || c_regs[320 +: 16] !== 16'hABCD) begin
      failures++; $display("FAIL oor_ignored got=%h/%h exp=ABCD/ABCD", c_regs[64 +: 16], c_regs[320 +: 16]);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_write = 1'b0; a_read = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
    a_hw_ro = '0; a_hw_set = '0;
    a_hw_ro[16 +: 16] = 16'h1234; a_hw_ro[32 +: 16] = 16'h7700; a_hw_ro[48 +: 16] = 16'hC3C3;
    b_rst_n = 1'b0; b_write = 1'b0; b_read = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    b_hw_ro = '0; b_hw_set = '0;
    c_rst_n = 1'b0; c_write = 1'b0; c_read = 1'b0; c_addr = '0; c_wdata = '0; c_be = '0;
    c_hw_ro = '0; c_hw_set = '0;
    repeat (3) tick();
    test_reset();
    test_read_ro();
    test_write();
    test_back_to_back();
    test_w1c();
    test_reset_flush();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amm_csr_bank.md
AMM_CSR_BANK -- requirements
Module: amm_csr_bank

Interface
REQ-001 Parameter REG_CNT, default 32, number of registers (2..256).
REQ-002 Parameter DATA_W, default 16, register width in bits (multiple of 8, 8..64).
REQ-003 Parameter READ_LAT, default 1, cycles from accepted read to readdatavalid (1..4).
REQ-004 Parameter RO_MASK, default per-register pattern 0000/00FF/FF00/FFFF repeating, set bit = read-only (hardware-driven) bit.
REQ-005 Parameter W1C_MASK, default all 0, set bit = sticky write-1-to-clear bit; RO_MASK takes precedence where both are set.
REQ-006 Parameter INIT, default 16'hABCD per register, reset value of RW and W1C bits.
REQ-007 Clocking is fixed: one clock; reset is asynchronous and active-low.
REQ-008 clk_i  in  1  sole clock; all logic on rising edge.
REQ-009 rst_n_i  in  1  asynchronous active-low reset.
REQ-010 amm_address_i  in  ADDR_W=$clog2(REG_CNT) (min 1)  word address.
REQ-011 amm_write_i  in  1  write strobe.
REQ-012 amm_writedata_i  in  DATA_W  write data.
REQ-013 amm_byteenable_i  in  DATA_W/8  byte lanes of write.
REQ-014 amm_read_i  in  1  read strobe.
REQ-015 amm_readdata_o  out  DATA_W  read data.
REQ-016 amm_readdatavalid_o  out  1  one-cycle pulse per accepted read.
REQ-017 amm_waitrequest_o  out  1  tied 0; every strobe accepted in its cycle.
REQ-018 hw_ro_i  in  REG_CNT*DATA_W  live values of RO bits.
REQ-019 hw_set_i  in  REG_CNT*DATA_W  per-bit one-cycle set pulses for W1C bits; ignored on non-W1C bits.
REQ-020 regs_o  out  REG_CNT*DATA_W  current register contents (RO bits show hw_ro_i).
REQ-021 irq_o  out  1  registered OR of all W1C bits.
REQ-022 err_cnt_o  out  8  saturating count of out-of-range accesses.

Function
REQ-023 Write: per bit with byte lane enabled -- RO bit unchanged; W1C bit cleared where writedata=1, kept where 0; RW bit takes writedata; new value visible on regs_o the cycle after the strobe.
REQ-024 Disabled byte lanes SHALL leave all their bits unchanged.
REQ-025 W1C bit with hw_set_i=1 SHALL be 1 next cycle; set and host clear in same cycle -> set wins.
REQ-026 Read: accepted in strobe cycle; data sampled that cycle (pre-write value if write to same address same cycle; RO bits from hw_ro_i that cycle); readdata and readdatavalid presented exactly READ_LAT cycles later.
REQ-027 Back-to-back reads every cycle SHALL be supported; responses in order, one per cycle.
REQ-028 amm_readdata_o SHALL hold its last value when readdatavalid is 0.
REQ-029 Address >= REG_CNT: write ignored; read returns 0 with normal valid timing; err_cnt_o increments by 1 per strobe cycle (read and write in same cycle count once), saturates at 255.
REQ-030 irq_o SHALL follow W1C state with one cycle latency.

Reset
REQ-031 On rst_n_i low, immediately: RW/W1C bits = INIT & ~RO_MASK, readdatavalid 0, readdata 0, read pipeline flushed (in-flight reads produce no response), err_cnt_o 0, irq_o = 0.
REQ-032 First strobe accepted on first rising edge with rst_n_i high.

Verification
REQ-033 Defaults, after reset read addr 1, hw_ro_i reg1 = 16'h1234 -> readdatavalid one cycle later, readdata 16'hAB34.
REQ-034 Write addr 0 data 16'h5A5A byteenable 2'b01 -> regs_o reg0 = 16'hAB5A; write addr 3 any data -> reg3 = hw_ro_i value.
REQ-035 W1C_MASK reg0 = 16'h000F, INIT reg0 = 16'h0000: hw_set_i bit2 pulse -> reg0 = 16'h0004, irq_o 1 next cycle; write 16'h0004 with simultaneous hw_set_i bit2 -> stays 16'h0004; write 16'h0004 alone -> 16'h0000, irq_o 0.
REQ-036 REG_CNT=24, READ_LAT=3: reads to addr 5, 30, 6 on consecutive cycles -> three valid pulses on cycles 3,4,5 later, middle data 0, err_cnt_o = 1; 300 out-of-range writes -> err_cnt_o = 255.
REQ-037 READ_LAT=2: read issued, rst_n_i low next cycle for 1 cycle -> no readdatavalid ever for that read, all registers at INIT.
